// File: rtl/undo_redo_hist.sv
// Linear undo/redo history of committed strokes in a DEPTH-entry circular buffer.
// Rising edges on save/undo/redo/clear drive exactly one action per cycle (clear > save > undo > redo).
module undo_redo_hist #(
    parameter int DEPTH = 8,
    parameter int X_W   = 8,
    parameter int Y_W   = 8,
    parameter int C_W   = 3,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           save,
    input  logic           undo,
    input  logic           redo,
    input  logic           clear,
    input  logic [X_W-1:0] x_in,
    input  logic [Y_W-1:0] y_in,
    input  logic [C_W-1:0] color_in,
    output logic [X_W-1:0] x_out,
    output logic [Y_W-1:0] y_out,
    output logic [C_W-1:0] color_out,
    output logic           restore_valid,
    output logic           restore_is_redo,
    output logic           dropped,
    output logic           can_undo,
    output logic           can_redo,
    output logic [CW-1:0]  undo_depth
);
    localparam int DW = X_W + Y_W + C_W;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [DW-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr, wr_n;
    logic [CW-1:0] count, cnt_n;
    logic [CW-1:0] redo_cnt, redo_n;
    logic          save_q, undo_q, redo_q, clear_q;

    logic          clear_f, save_f, undo_f, redo_f;
    logic [CW-1:0] ud;
    logic [AW-1:0] slot, rd_idx;
    logic          wr_en, rd_en, rd_is_redo, drop_n;

    assign clear_f = clear & ~clear_q;
    assign save_f  = save  & ~save_q;
    assign undo_f  = undo  & ~undo_q;
    assign redo_f  = redo  & ~redo_q;

    assign ud       = count - redo_cnt;
    // The slot just past the undoable region: next save target and next redo source.
    assign slot     = wr_ptr - redo_cnt[AW-1:0];
    assign can_undo = (undo_depth != '0);
    assign can_redo = (redo_cnt != '0);

    // An edge claims the cycle even when its action is blocked; lower edges are dropped.
    always_comb begin
        wr_n       = wr_ptr;
        cnt_n      = count;
        redo_n     = redo_cnt;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        rd_is_redo = 1'b0;
        rd_idx     = slot;
        drop_n     = 1'b0;
        if (clear_f) begin
            wr_n   = '0;
            cnt_n  = '0;
            redo_n = '0;
        end else if (save_f) begin
            wr_en  = 1'b1;
            wr_n   = slot + 1'b1;
            redo_n = '0;
            drop_n = (ud == FULL);
            cnt_n  = (ud == FULL) ? FULL : ud + 1'b1;
        end else if (undo_f) begin
            if (ud != '0) begin
                rd_en  = 1'b1;
                rd_idx = slot - 1'b1;
                redo_n = redo_cnt + 1'b1;
            end
        end else if (redo_f) begin
            if (redo_cnt != '0) begin
                rd_en      = 1'b1;
                rd_is_redo = 1'b1;
                redo_n     = redo_cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[slot] <= {x_in, y_in, color_in};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            save_q          <= 1'b0;
            undo_q          <= 1'b0;
            redo_q          <= 1'b0;
            clear_q         <= 1'b0;
            wr_ptr          <= '0;
            count           <= '0;
            redo_cnt        <= '0;
            undo_depth      <= '0;
            x_out           <= '0;
            y_out           <= '0;
            color_out       <= '0;
            restore_valid   <= 1'b0;
            restore_is_redo <= 1'b0;
            dropped         <= 1'b0;
        end else begin
            save_q        <= save;
            undo_q        <= undo;
            redo_q        <= redo;
            clear_q       <= clear;
            wr_ptr        <= wr_n;
            count         <= cnt_n;
            redo_cnt      <= redo_n;
            undo_depth    <= cnt_n - redo_n;
            restore_valid <= rd_en;
            dropped       <= drop_n;
            if (rd_en) begin
                {x_out, y_out, color_out} <= mem[rd_idx];
                restore_is_redo           <= rd_is_redo;
            end
        end
    end
endmodule

// File: tb/tb_undo_redo_hist.sv
// Bench for undo_redo_hist: four depth/width variants share one stimulus stream,
// each checked against an independent array-based history model and a restore queue.
module tb_undo_redo_hist;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       save_i = 1'b0, undo_i = 1'b0, redo_i = 1'b0, clear_i = 1'b0;
    logic [9:0] x_i = '0, y_i = '0;
    logic [3:0] c_i = '0;

    always #5 clk = ~clk;

    logic [7:0] x8,  y8,  x4,  y4;
    logic [2:0] c8,  c4;
    logic [9:0] x2,  y2,  x16, y16;
    logic [3:0] c2,  c16;
    logic [3:0] ud8;
    logic [2:0] ud4;
    logic [1:0] ud2;
    logic [4:0] ud16;
    logic       rv [4], isr [4], drp [4], cu [4], cr [4];
    logic [9:0] x_o [4], y_o [4];
    logic [3:0] c_o [4];
    logic [4:0] ud_o [4];

    undo_redo_hist #(.DEPTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .save(save_i), .undo(undo_i), .redo(redo_i), .clear(clear_i),
        .x_in(x_i[7:0]), .y_in(y_i[7:0]), .color_in(c_i[2:0]), .x_out(x8), .y_out(y8), .color_out(c8),
        .restore_valid(rv[0]), .restore_is_redo(isr[0]), .dropped(drp[0]), .can_undo(cu[0]),
        .can_redo(cr[0]), .undo_depth(ud8));
    undo_redo_hist #(.DEPTH(4)) u4 (
        .clk(clk), .rst_n(rst_n), .save(save_i), .undo(undo_i), .redo(redo_i), .clear(clear_i),
        .x_in(x_i[7:0]), .y_in(y_i[7:0]), .color_in(c_i[2:0]), .x_out(x4), .y_out(y4), .color_out(c4),
        .restore_valid(rv[1]), .restore_is_redo(isr[1]), .dropped(drp[1]), .can_undo(cu[1]),
        .can_redo(cr[1]), .undo_depth(ud4));
    undo_redo_hist #(.DEPTH(2), .X_W(10), .Y_W(10), .C_W(4)) u2 (
        .clk(clk), .rst_n(rst_n), .save(save_i), .undo(undo_i), .redo(redo_i), .clear(clear_i),
        .x_in(x_i), .y_in(y_i), .color_in(c_i), .x_out(x2), .y_out(y2), .color_out(c2),
        .restore_valid(rv[2]), .restore_is_redo(isr[2]), .dropped(drp[2]), .can_undo(cu[2]),
        .can_redo(cr[2]), .undo_depth(ud2));
    undo_redo_hist #(.DEPTH(16), .X_W(10), .Y_W(10), .C_W(4)) u16 (
        .clk(clk), .rst_n(rst_n), .save(save_i), .undo(undo_i), .redo(redo_i), .clear(clear_i),
        .x_in(x_i), .y_in(y_i), .color_in(c_i), .x_out(x16), .y_out(y16), .color_out(c16),
        .restore_valid(rv[3]), .restore_is_redo(isr[3]), .dropped(drp[3]), .can_undo(cu[3]),
        .can_redo(cr[3]), .undo_depth(ud16));

    assign x_o[0] = {2'b00, x8};  assign y_o[0] = {2'b00, y8};  assign c_o[0] = {1'b0, c8};
    assign x_o[1] = {2'b00, x4};  assign y_o[1] = {2'b00, y4};  assign c_o[1] = {1'b0, c4};
    assign x_o[2] = x2;           assign y_o[2] = y2;           assign c_o[2] = c2;
    assign x_o[3] = x16;          assign y_o[3] = y16;          assign c_o[3] = c16;
    assign ud_o[0] = {1'b0, ud8}; assign ud_o[1] = {2'b00, ud4};
    assign ud_o[2] = {3'b000, ud2}; assign ud_o[3] = ud16;

    // Reference model: entry = {x[9:0], y[9:0], c[3:0]}
    int          dep [4] = '{8, 4, 2, 16};
    logic [9:0]  xm  [4] = '{10'h0ff, 10'h0ff, 10'h3ff, 10'h3ff};
    logic [3:0]  cm  [4] = '{4'h7, 4'h7, 4'hf, 4'hf};
    int          m_wr [4], m_cnt [4], m_redo [4];
    logic [23:0] m_buf [4][16];
    logic [23:0] m_out [4];
    logic        m_pulse [4], m_drop [4];
    logic        p_s, p_u, p_r, p_c;
    logic [26:0] exp_q [$];

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_wr[k] = 0; m_cnt[k] = 0; m_redo[k] = 0;
            m_out[k] = '0; m_pulse[k] = 1'b0; m_drop[k] = 1'b0;
        end
        p_s = 1'b0; p_u = 1'b0; p_r = 1'b0; p_c = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_step();
        logic fs, fu, fr, fc;
        int   idx;
        fc = clear_i & ~p_c;
        fs = save_i & ~p_s;
        fu = undo_i & ~p_u;
        fr = redo_i & ~p_r;
        for (int k = 0; k < 4; k++) begin
            m_pulse[k] = 1'b0;
            m_drop[k]  = 1'b0;
            if (fc) begin
                m_wr[k] = 0; m_cnt[k] = 0; m_redo[k] = 0;
            end else if (fs) begin
                idx = (m_wr[k] - m_redo[k]) & (dep[k] - 1);
                m_buf[k][idx] = {x_i & xm[k], y_i & xm[k], c_i & cm[k]};
                m_drop[k] = (m_cnt[k] - m_redo[k] == dep[k]);
                m_cnt[k]  = m_drop[k] ? dep[k] : m_cnt[k] - m_redo[k] + 1;
                m_redo[k] = 0;
                m_wr[k]   = (idx + 1) & (dep[k] - 1);
            end else if (fu) begin
                if (m_cnt[k] - m_redo[k] > 0) begin
                    idx = (m_wr[k] - m_redo[k] - 1) & (dep[k] - 1);
                    m_out[k] = m_buf[k][idx];
                    m_pulse[k] = 1'b1;
                    exp_q.push_back({2'(k), 1'b0, m_out[k]});
                    m_redo[k]++;
                end
            end else if (fr) begin
                if (m_redo[k] > 0) begin
                    idx = (m_wr[k] - m_redo[k]) & (dep[k] - 1);
                    m_out[k] = m_buf[k][idx];
                    m_pulse[k] = 1'b1;
                    exp_q.push_back({2'(k), 1'b1, m_out[k]});
                    m_redo[k]--;
                end
            end
        end
        p_s = save_i; p_u = undo_i; p_r = redo_i; p_c = clear_i;
    endtask

    task automatic check_all();
        logic [26:0] got;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("restore_valid[%0d]", k), rv[k], m_pulse[k]);
            if (m_pulse[k] && exp_q.size() > 0) begin
                got = exp_q.pop_front();
                chk($sformatf("restore_entry[%0d]", k), {2'(k), isr[k], x_o[k], y_o[k], c_o[k]}, got);
            end
            chk($sformatf("out_hold[%0d]", k), {x_o[k], y_o[k], c_o[k]}, m_out[k]);
            chk($sformatf("undo_depth[%0d]", k), ud_o[k], m_cnt[k] - m_redo[k]);
            chk($sformatf("can_undo[%0d]", k), cu[k], (m_cnt[k] - m_redo[k]) > 0);
            chk($sformatf("can_redo[%0d]", k), cr[k], m_redo[k] > 0);
            chk($sformatf("dropped[%0d]", k), drp[k], m_drop[k]);
        end
    endtask

    task automatic tick(input logic s, u, r, c, input logic [9:0] x, y, input logic [3:0] col);
        save_i = s; undo_i = u; redo_i = r; clear_i = c;
        x_i = x; y_i = y; c_i = col;
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    // op: 0 save, 1 undo, 2 redo, 3 clear; pulse high for one edge then low for one
    task automatic act(input int op, input logic [9:0] v);
        tick(op == 0, op == 1, op == 2, op == 3, v, v, v[3:0]);
        tick(1'b0, 1'b0, 1'b0, 1'b0, v, v, v[3:0]);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        chk("reset_undo_depth", ud8, 0);
        chk("reset_can_undo", cu[0], 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic undo/redo chain
        for (int v = 1; v <= 3; v++) act(0, 10'(v));
        for (int i = 0; i < 4; i++) act(1, 10'd0);
        chk("undo_exhausted", cu[0], 0);
        for (int i = 0; i < 4; i++) act(2, 10'd0);
        chk("redo_back_x", x8, 3);

        // Overflow on small depths
        act(3, 10'd0);
        for (int v = 1; v <= 5; v++) act(0, 10'(v));
        for (int i = 0; i < 5; i++) act(1, 10'd0);
        chk("d4_last_undo_x", x4, 2);

        // Save truncates the redo branch
        act(3, 10'd0);
        for (int v = 1; v <= 3; v++) act(0, 10'(v));
        act(1, 10'd0); act(1, 10'd0);
        act(0, 10'd9);
        chk("trunc_can_redo", cr[0], 0);
        chk("trunc_undo_depth", ud8, 2);
        act(1, 10'd0);
        chk("trunc_undo_x", x8, 9);
        act(1, 10'd0);
        chk("trunc_undo2_x", x8, 1);

        // Same-cycle edges resolved by priority
        act(3, 10'd0);
        act(0, 10'd1); act(0, 10'd2);
        tick(1'b1, 1'b1, 1'b0, 1'b0, 10'd7, 10'd7, 4'd7);
        chk("save_beats_undo_pulse", rv[0], 0);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 10'd7, 10'd7, 4'd7);
        tick(1'b0, 1'b0, 1'b1, 1'b1, 10'd0, 10'd0, 4'd0);
        chk("clear_beats_redo", ud8, 0);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0, 4'd0);

        // Held request and reset mid-hold
        act(3, 10'd0);
        for (int v = 1; v <= 3; v++) act(0, 10'(v));
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 1'b0, 1'b0, 10'd0, 10'd0, 4'd0);
        chk("hold_one_undo_depth", ud8, 2);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_rst_x", x8, 0);
        chk("async_rst_depth", ud8, 0);
        chk("async_rst_can_redo", cr[0], 0);
        check_all();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick(1'b0, 1'b1, 1'b0, 1'b0, 10'd0, 10'd0, 4'd0);
        chk("rst_release_no_restore", rv[0], 0);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0, 4'd0);

        // Random sweep across all variants
        for (int i = 0; i < 600; i++) begin
            tick($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 15) == 0, 10'($urandom_range(0, 1023)),
                 10'($urandom_range(0, 1023)), 4'($urandom_range(0, 15)));
        end
        chk("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/undo_redo_hist.md
# undo_redo_hist

Parametrised linear undo/redo history for the drawing pipeline: records committed strokes (x, y, colour) in a DEPTH-entry circular buffer and replays them one at a time on undo/redo requests, emitting a one-cycle restore pulse to the framebuffer writer. It sits between the debounced button front-end and the pixel write arbiter. Compared with the fixed 4-entry history, it adds:
- configurable depth and field widths;
- truncation of the redo branch on save;
- a clear command and fixed one-action-per-cycle priority;
- occupancy and overflow status outputs.

## Interface
- DEPTH, 8: history entries; power of two, ≥2.
- X_W, 8: x coordinate width.
- Y_W, 8: y coordinate width.
- C_W, 3: colour width.
- AW = $clog2(DEPTH) (pointer width); CW = $clog2(DEPTH+1) (count width). Both are derived; not overridable.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- save  in  1  level request; acts on rising edge.
- undo  in  1  level request; acts on rising edge.
- redo  in  1  level request; acts on rising edge.
- clear  in  1  level request; acts on rising edge; empties history.
- x_in  in  X_W  stroke x, sampled on save action.
- y_in  in  Y_W  stroke y, sampled on save action.
- color_in  in  C_W  stroke colour, sampled on save action.
- x_out  out  X_W  replayed entry x.
- y_out  out  Y_W  replayed entry y.
- color_out  out  C_W  replayed entry colour.
- restore_valid  out  1  one-cycle pulse; *_out are valid this cycle.
- restore_is_redo  out  1  qualifies restore_valid: 0 = undo, 1 = redo.
- dropped  out  1  one-cycle pulse when a save overwrote the oldest entry.
- can_undo  out  1  combinational: undo_depth > 0.
- can_redo  out  1  combinational: redo_cnt > 0.
- undo_depth  out  CW  registered: number of undoable entries.

## Operation
- State:
  - wr_ptr[AW]: next write slot.
  - count[CW]: valid entries, 0..DEPTH.
  - redo_cnt[CW]: redoable entries, 0..count.
  - undo_depth = count − redo_cnt.
- Edge detection: one prev register per request input, updated every cycle. A request fires when input=1 and prev=0.
- One action per cycle. Priority: clear > save > undo > redo.
  - Lower-priority edges in the same cycle are discarded, not queued. Their prev registers still update.
- clear: wr_ptr, count, redo_cnt ← 0. No restore pulse. Buffer contents are left stale.
- save:
  - Write slot s = wr_ptr − redo_cnt (mod DEPTH); write x_in/y_in/color_in there.
  - wr_ptr ← s+1.
  - redo_cnt ← 0.
  - count ← min(count − redo_cnt + 1, DEPTH).
  - dropped ← 1 iff count − redo_cnt = DEPTH before the save.
- undo (ignored if can_undo=0):
  - Output buf[wr_ptr − redo_cnt − 1].
  - redo_cnt ← redo_cnt+1.
  - restore_valid ← 1, restore_is_redo ← 0.
- redo (ignored if can_redo=0):
  - Output buf[wr_ptr − redo_cnt].
  - redo_cnt ← redo_cnt−1.
  - restore_valid ← 1, restore_is_redo ← 1.
- Pointer arithmetic is modulo DEPTH (AW bits). count and redo_cnt never wrap.
- Ignored or blocked requests change no state and produce no pulse.
- *_out hold their last value between restores.

## Timing
- Reset (asynchronous assert): all state, prev registers and outputs go to 0. can_undo = can_redo = 0.
  - The buffer may reset to 0 or remain unreset; the bench must not depend on its contents.
- Request high at edge N with prev low: the action commits at edge N. Registered outputs (x/y/color_out, restore_valid, restore_is_redo, dropped, undo_depth) are visible after edge N, for one cycle in the case of the pulses.
- Holding a request high does not repeat the action. It must return low for at least one sampled edge before it can fire again.
- Request asserted during reset: prev = 0 after reset release, so a still-high input fires on the first active edge.
- Reset mid-sequence discards all history immediately.

## Test plan
- Save (1,1,1), (2,2,2), (3,3,3); undo ×3 → outputs 3,2,1 with restore_is_redo=0; 4th undo → no pulse, can_undo=0; redo ×3 → outputs 1,2,3 with restore_is_redo=1.
- DEPTH=4: save 5 entries (values 1..5) → dropped pulses on the 5th save only; undo ×4 → 5,4,3,2; 5th undo ignored.
- Save 1,2,3; undo ×2; save 9 → can_redo=0, undo_depth=2; undo → 9; undo → 1.
- save and undo rising in the same cycle with count=2 → save only, no restore pulse; clear and redo in the same cycle → history empty, no pulse.
- Hold undo high for 5 cycles with 3 entries → exactly one restore; assert rst_n low mid-hold → all outputs 0 immediately; release with undo high → no restore (empty).
- Parameter sweep DEPTH=2,16 with X_W=Y_W=10, C_W=4: random save/undo/redo/clear against a reference model; x/y/color_out, undo_depth and can_* match every cycle.
